// File: rtl/mem_ctrl_pkg.sv
// mem_ctrl_pkg: shared FSM state encoding, access-size codes and alignment helper
// for the data memory controller.
`default_nettype none

package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    REQ   = 2'd1,
    RWAIT = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Size 2'b11 has no natural width, so it is always treated as an error case.
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
    logic bad;
    bad = 1'b0;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = addr_lo[0];
      SZ_WORD: bad = |addr_lo;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

`default_nettype wire

// File: rtl/byte_lane_align.sv
// byte_lane_align: combinational lane mapping (byte enables, store-data shift and
// load-data shift with zero fill) shared by the write and read paths.
`default_nettype none

module byte_lane_align
  import mem_ctrl_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  offset,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata_aligned,
  output logic [31:0] rdata_aligned
);

  logic [1:0]  lane;
  logic [31:0] rdata_shifted;

  always_comb begin
    lane = 2'd0;
    be   = 4'b1111;
    case (size)
      SZ_BYTE: begin
        lane = offset;
        be   = 4'b0001 << offset;
      end
      SZ_HALF: begin
        lane = {offset[1], 1'b0};
        be   = 4'b0011 << {offset[1], 1'b0};
      end
      // Words, and the unused size code, always occupy the full bus.
      default: begin
        lane = 2'd0;
        be   = 4'b1111;
      end
    endcase
  end

  always_comb begin
    wdata_aligned = wdata << {lane, 3'b000};
    rdata_shifted = rdata >> {lane, 3'b000};
    case (size)
      SZ_BYTE: rdata_aligned = {24'd0, rdata_shifted[7:0]};
      SZ_HALF: rdata_aligned = {16'd0, rdata_shifted[15:0]};
      default: rdata_aligned = rdata_shifted;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: bridges load/store requests onto a req/gnt/rvalid word bus.
// Optional macro MISALIGN_CHECK_EN rejects misaligned halves/words with misalign_err.
`default_nettype none

module data_mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        CLK,
  input  logic        resetn,
  input  logic        mem_en,
  input  logic        mem_we,
  input  logic [2:0]  funct3,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic [31:0] mem_read_data,
  output logic        mem_read_data_valid,
  output logic        mem_write_ready,
  output logic        misalign_err,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_be,
  output logic [31:0] bus_wdata,
  input  logic        bus_gnt,
  input  logic        bus_rvalid,
  input  logic [31:0] bus_rdata
);

  state_t      state;
  state_t      state_next;

  logic [31:0] addr_q;
  logic        we_q;
  logic [1:0]  size_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_aligned;
  logic        accept;
  logic        misalign_now;

  logic        unused_funct3_msb;
  assign unused_funct3_msb = funct3[2];

  assign accept = (state == IDLE) && mem_en;

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;
  assign misalign_now = is_misaligned(funct3[1:0], mem_addr[1:0]);
`else
  assign misalign_now = 1'b0;
`endif

  byte_lane_align u_align (
    .size          (size_q),
    .offset        (addr_q[1:0]),
    .wdata         (wdata_q),
    .rdata         (bus_rdata),
    .be            (bus_be),
    .wdata_aligned (bus_wdata),
    .rdata_aligned (rdata_aligned)
  );

  assign bus_we   = we_q;
  assign bus_addr = {addr_q[31:2], 2'b00};

  always_ff @(posedge CLK) begin
    if (!resetn) begin
      state         <= IDLE;
      addr_q        <= 32'd0;
      we_q          <= 1'b0;
      size_q        <= 2'd0;
      wdata_q       <= 32'd0;
      mem_read_data <= 32'd0;
    end else begin
      state <= state_next;
      if (accept) begin
        addr_q  <= mem_addr;
        we_q    <= mem_we;
        size_q  <= funct3[1:0];
        wdata_q <= mem_wdata;
      end
      if ((state == RWAIT) && bus_rvalid) begin
        mem_read_data <= rdata_aligned;
      end
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge CLK) begin
    if (!resetn) begin
      misalign_q <= 1'b0;
    end else if (accept) begin
      misalign_q <= misalign_now;
    end
  end
`endif

  always_comb begin
    state_next          = state;
    bus_req             = 1'b0;
    mem_read_data_valid = 1'b0;
    mem_write_ready     = 1'b0;
    misalign_err        = 1'b0;
    case (state)
      IDLE: begin
        // A rejected access skips the bus entirely and goes straight to its response.
        if (mem_en) begin
          state_next = misalign_now ? RESP : REQ;
        end
      end
      REQ: begin
        bus_req = 1'b1;
        if (bus_gnt) begin
          state_next = we_q ? RESP : RWAIT;
        end
      end
      RWAIT: begin
        if (bus_rvalid) begin
          state_next = RESP;
        end
      end
      RESP: begin
        state_next = IDLE;
`ifdef MISALIGN_CHECK_EN
        if (misalign_q) begin
          misalign_err = 1'b1;
        end else if (we_q) begin
          mem_write_ready = 1'b1;
        end else begin
          mem_read_data_valid = 1'b1;
        end
`else
        if (we_q) begin
          mem_write_ready = 1'b1;
        end else begin
          mem_read_data_valid = 1'b1;
        end
`endif
      end
      default: state_next = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed self-checking bench for data_mem_ctrl
// (covers both builds of MISALIGN_CHECK_EN).
`default_nettype none

module tb_data_mem_ctrl;

  logic        CLK = 1'b0;
  logic        resetn;
  logic        mem_en;
  logic        mem_we;
  logic [2:0]  funct3;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_read_data;
  logic        mem_read_data_valid;
  logic        mem_write_ready;
  logic        misalign_err;
  logic        bus_req;
  logic        bus_we;
  logic [31:0] bus_addr;
  logic [3:0]  bus_be;
  logic [31:0] bus_wdata;
  logic        bus_gnt;
  logic        bus_rvalid;
  logic [31:0] bus_rdata;

  int n_assert = 0;
  int n_fail   = 0;

  data_mem_ctrl dut (
    .CLK                 (CLK),
    .resetn              (resetn),
    .mem_en              (mem_en),
    .mem_we              (mem_we),
    .funct3              (funct3),
    .mem_addr            (mem_addr),
    .mem_wdata           (mem_wdata),
    .mem_read_data       (mem_read_data),
    .mem_read_data_valid (mem_read_data_valid),
    .mem_write_ready     (mem_write_ready),
    .misalign_err        (misalign_err),
    .bus_req             (bus_req),
    .bus_we              (bus_we),
    .bus_addr            (bus_addr),
    .bus_be              (bus_be),
    .bus_wdata           (bus_wdata),
    .bus_gnt             (bus_gnt),
    .bus_rvalid          (bus_rvalid),
    .bus_rdata           (bus_rdata)
  );

  always #5 CLK = ~CLK;

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_pulses(input string tag, input logic rv, input logic wr, input logic me);
    chk({tag, "_rvalid"}, {31'd0, mem_read_data_valid}, {31'd0, rv});
    chk({tag, "_wready"}, {31'd0, mem_write_ready}, {31'd0, wr});
    chk({tag, "_merr"}, {31'd0, misalign_err}, {31'd0, me});
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    mem_en    = 1'b1;
    mem_we    = we;
    funct3    = f3;
    mem_addr  = a;
    mem_wdata = d;
  endtask

  initial begin
    resetn     = 1'b0;
    mem_en     = 1'b0;
    mem_we     = 1'b0;
    funct3     = 3'd0;
    mem_addr   = 32'd0;
    mem_wdata  = 32'd0;
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b0;
    bus_rdata  = 32'd0;

    // Reset state
    tick();
    tick();
    chk("rst_req", {31'd0, bus_req}, 32'd0);
    chk("rst_rdata", mem_read_data, 32'd0);
    chk("rst_addr", bus_addr, 32'd0);
    chk_pulses("rst", 1'b0, 1'b0, 1'b0);
    resetn = 1'b1;
    tick();

    // SW 0x100 <- DEADBEEF, grant in first REQ cycle
    issue(1'b1, 3'b010, 32'h0000_0100, 32'hDEAD_BEEF);
    tick();
    mem_en = 1'b0;
    chk("sw_req", {31'd0, bus_req}, 32'd1);
    chk("sw_we", {31'd0, bus_we}, 32'd1);
    chk("sw_addr", bus_addr, 32'h0000_0100);
    chk("sw_be", {28'd0, bus_be}, 32'hF);
    chk("sw_wdata", bus_wdata, 32'hDEAD_BEEF);
    chk_pulses("sw_c1", 1'b0, 1'b0, 1'b0);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk_pulses("sw_c2", 1'b0, 1'b1, 1'b0);
    chk("sw_req_drop", {31'd0, bus_req}, 32'd0);
    tick();
    chk_pulses("sw_c3", 1'b0, 1'b0, 1'b0);

    // SB 0x103 <- A5
    issue(1'b1, 3'b000, 32'h0000_0103, 32'h0000_00A5);
    tick();
    mem_en = 1'b0;
    chk("sb_addr", bus_addr, 32'h0000_0100);
    chk("sb_be", {28'd0, bus_be}, 32'h8);
    chk("sb_wdata", bus_wdata, 32'hA500_0000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk_pulses("sb_resp", 1'b0, 1'b1, 1'b0);
    tick();

    // SH 0x002 <- 1234 (upper half lanes)
    issue(1'b1, 3'b001, 32'h0000_0002, 32'h0000_1234);
    tick();
    mem_en = 1'b0;
    chk("sh_be", {28'd0, bus_be}, 32'hC);
    chk("sh_wdata", bus_wdata, 32'h1234_0000);
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    chk_pulses("sh_resp", 1'b0, 1'b1, 1'b0);
    tick();

    // LH 0x202: grant held off 3 cycles, rvalid after 2 RWAIT cycles
    issue(1'b0, 3'b001, 32'h0000_0202, 32'h0);
    tick();
    mem_en = 1'b0;
    chk("lh_we", {31'd0, bus_we}, 32'd0);
    chk("lh_addr", bus_addr, 32'h0000_0200);
    chk("lh_be", {28'd0, bus_be}, 32'hC);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("lh_req_held", {31'd0, bus_req}, 32'd1);
      chk_pulses("lh_wait", 1'b0, 1'b0, 1'b0);
    end
    bus_gnt = 1'b1;
    tick();
    bus_gnt = 1'b0;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk_pulses("lh_rwait", 1'b0, 1'b0, 1'b0);
    end
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h8001_1234;
    tick();
    bus_rvalid = 1'b0;
    bus_rdata  = 32'h0;
    chk_pulses("lh_resp", 1'b1, 1'b0, 1'b0);
    chk("lh_data", mem_read_data, 32'h0000_8001);
    tick();
    chk_pulses("lh_after", 1'b0, 1'b0, 1'b0);
    chk("lh_hold", mem_read_data, 32'h0000_8001);

    // LW 0x400: mem_en dropped in REQ, grant delayed 4 cycles
    issue(1'b0, 3'b010, 32'h0000_0400, 32'h0);
    tick();
    mem_en = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lw_req_held", {31'd0, bus_req}, 32'd1);
      tick();
    end
    chk("lw_req_still", {31'd0, bus_req}, 32'd1);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'h1234_5678;
    tick();
    bus_rvalid = 1'b0;
    chk_pulses("lw_resp", 1'b1, 1'b0, 1'b0);
    chk("lw_data", mem_read_data, 32'h1234_5678);
    // mem_en during RESP must not launch a new access
    issue(1'b0, 3'b010, 32'h0000_0700, 32'h0);
    tick();
    mem_en = 1'b0;
    chk_pulses("lw_after", 1'b0, 1'b0, 1'b0);
    chk("resp_en_ignored", {31'd0, bus_req}, 32'd0);
    tick();
    chk("resp_en_still_idle", {31'd0, bus_req}, 32'd0);

    // LW 0x301 misaligned
    issue(1'b0, 3'b010, 32'h0000_0301, 32'h0);
    tick();
    mem_en = 1'b0;
`ifdef MISALIGN_CHECK_EN
    chk("mis_noreq", {31'd0, bus_req}, 32'd0);
    chk_pulses("mis_resp", 1'b0, 1'b0, 1'b1);
    chk("mis_data_kept", mem_read_data, 32'h1234_5678);
    tick();
    chk_pulses("mis_after", 1'b0, 1'b0, 1'b0);
`else
    chk("mis_req", {31'd0, bus_req}, 32'd1);
    chk("mis_addr", bus_addr, 32'h0000_0300);
    chk("mis_be", {28'd0, bus_be}, 32'hF);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hCAFE_F00D;
    tick();
    bus_rvalid = 1'b0;
    chk_pulses("mis_resp", 1'b1, 1'b0, 1'b0);
    chk("mis_data", mem_read_data, 32'hCAFE_F00D);
    tick();
`endif

    // Reset asserted while waiting for read data
    issue(1'b0, 3'b010, 32'h0000_0500, 32'h0);
    tick();
    mem_en  = 1'b0;
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    resetn     = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hFFFF_FFFF;
    tick();
    resetn = 1'b1;
    chk("rwrst_req", {31'd0, bus_req}, 32'd0);
    chk_pulses("rwrst", 1'b0, 1'b0, 1'b0);
    chk("rwrst_data", mem_read_data, 32'd0);
    tick();
    bus_rvalid = 1'b0;
    chk_pulses("rwrst_next", 1'b0, 1'b0, 1'b0);
    chk("rwrst_next_req", {31'd0, bus_req}, 32'd0);

    // Following LB 0x601 behaves normally
    issue(1'b0, 3'b000, 32'h0000_0601, 32'h0);
    tick();
    mem_en = 1'b0;
    chk("lb_req", {31'd0, bus_req}, 32'd1);
    chk("lb_addr", bus_addr, 32'h0000_0600);
    chk("lb_be", {28'd0, bus_be}, 32'h2);
    bus_gnt = 1'b1;
    tick();
    bus_gnt    = 1'b0;
    bus_rvalid = 1'b1;
    bus_rdata  = 32'hAABB_CCDD;
    tick();
    bus_rvalid = 1'b0;
    chk_pulses("lb_resp", 1'b1, 1'b0, 1'b0);
    chk("lb_data", mem_read_data, 32'h0000_00CC);
    tick();
    chk_pulses("lb_after", 1'b0, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
